// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared types and constants for the frame update sequencer.
// State encoding, default 640x480 raster geometry and named stage indices.
package frame_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_V_VISIBLE = 480;
  localparam int V_TOTAL       = 525;

  localparam int STG_W = 3;

  localparam logic [STG_W-1:0] STG_INPUT   = 3'd0;
  localparam logic [STG_W-1:0] STG_PLAYER  = 3'd1;
  localparam logic [STG_W-1:0] STG_OBST    = 3'd2;
  localparam logic [STG_W-1:0] STG_COLLIDE = 3'd3;

endpackage

// File: rtl/raster_event_detect.sv
// raster_event_detect: decodes the start of vertical blanking and the
// start-of-visible-frame deadline from the sync generator's raster position.
module raster_event_detect
  import frame_seq_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int V_VISIBLE = DEF_V_VISIBLE
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       vblank_start,
  output logic       deadline
);

  logic col0;

  // A raster with no visible columns never produces events.
  assign col0 = (x == 10'd0) && (x < 10'(H_VISIBLE));

  assign vblank_start = col0 && (y == 10'(V_VISIBLE));
  assign deadline     = col0 && (y == 10'd0);

endmodule

// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer: runs the game-logic stages in order during vblank.
// Define FRAME_COUNT_EN to build the completed-sequence counter.
module frame_update_sequencer
  import frame_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int V_VISIBLE  = DEF_V_VISIBLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  enable,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  frame_tick,
  output logic                  busy,
  output logic                  overrun,
  output logic [2:0]            overrun_stage,
  output logic [15:0]           frame_count
);

  seq_state_e state_q, state_d;

  logic [STG_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic                  tick_q, tick_d;
  logic                  ovr_q, ovr_d;
  logic [STG_W-1:0]      ostg_q, ostg_d;

  logic vblank_start;
  logic deadline;
  logic done_cur;
  logic last_stg;
  logic issue;

  raster_event_detect #(
    .H_VISIBLE(H_VISIBLE),
    .V_VISIBLE(V_VISIBLE)
  ) u_evt (
    .x           (x),
    .y           (y),
    .vblank_start(vblank_start),
    .deadline    (deadline)
  );

  always_comb begin
    done_cur = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == STG_W'(i)) done_cur = stage_done[i];
    end
  end

  assign last_stg = (idx_q == STG_W'(NUM_STAGES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    ovr_d   = ovr_q;
    ostg_d  = ostg_q;
    issue   = 1'b0;
    start_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (vblank_start && enable) begin
          state_d = S_RUN;
          idx_d   = '0;
          tick_d  = 1'b1;
          issue   = 1'b1;
        end
      end
      S_RUN: begin
        // The visible-frame deadline beats a same-cycle completion.
        if (deadline) begin
          state_d = S_IDLE;
          ovr_d   = 1'b1;
          ostg_d  = idx_q;
        end else if (done_cur) begin
          if (last_stg) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
            issue = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        start_d[i] = (idx_d == STG_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      start_q <= '0;
      tick_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ostg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      tick_q  <= tick_d;
      ovr_q   <= ovr_d;
      ostg_q  <= ostg_d;
    end
  end

`ifdef FRAME_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // DONE is only ever entered from the last RUN stage.
  assign cnt_d = (state_d == S_DONE) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign frame_count = cnt_q;
`else
  assign frame_count = 16'd0;
`endif

  assign stage_start   = start_q;
  assign frame_tick    = tick_q;
  assign busy          = (state_q == S_RUN);
  assign overrun       = ovr_q;
  assign overrun_stage = ostg_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// tb_frame_update_sequencer: directed scenarios with a cycle-tagged
// expectation queue drained by an independent monitor.
module tb_frame_update_sequencer;

  localparam int SIG_START = 0;
  localparam int SIG_TICK  = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_OVR   = 3;
  localparam int SIG_OSTG  = 4;
  localparam int SIG_CNT   = 5;

  localparam int M_RESP = 0;
  localparam int M_ZERO = 1;
  localparam int M_MAN  = 2;

  typedef struct {
    int          cyc;
    string       nm;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        enable;
  logic [3:0]  stage_done;
  logic [3:0]  stage_start;
  logic        frame_tick;
  logic        busy;
  logic        overrun;
  logic [2:0]  overrun_stage;
  logic [15:0] frame_count;

  int         mode = M_RESP;
  logic [3:0] man_done = 4'h0;
  logic [3:0] block_mask = 4'h0;
  logic [3:0] resp_done = 4'h0;
  int         pending[4] = '{default: -100};

  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;
  bit   inv_on = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  frame_update_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .enable       (enable),
    .stage_done   (stage_done),
    .stage_start  (stage_start),
    .frame_tick   (frame_tick),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_stage(overrun_stage),
    .frame_count  (frame_count)
  );

  assign stage_done = (mode == M_ZERO) ? 4'hF :
                      (mode == M_MAN)  ? man_done :
                      (resp_done & ~block_mask);

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: done pulse three cycles after each start pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (stage_start[i] === 1'b1) pending[i] = cyc + 3;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) resp_done[i] = (pending[i] == cyc);
  end

  function automatic logic [31:0] sample(int s);
    case (s)
      SIG_START: return 32'(stage_start);
      SIG_TICK:  return 32'(frame_tick);
      SIG_BUSY:  return 32'(busy);
      SIG_OVR:   return 32'(overrun);
      SIG_OSTG:  return 32'(overrun_stage);
      SIG_CNT:   return 32'(frame_count);
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] cnt(int n);
`ifdef FRAME_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      act = sample(e.sig);
      nvec++;
      if (e.cyc != cyc || act !== e.val) begin
        nbad++;
        $display("FAIL %s cyc=%0d got=%0h want=%0h (due %0d)",
                 e.nm, cyc, act, e.val, e.cyc);
      end
    end
    if (inv_on && $countones(stage_start) > 1) begin
      nvec++;
      nbad++;
      $display("FAIL onehot cyc=%0d got=%b want=at most one bit",
               cyc, stage_start);
    end
  end

  task automatic ex(int c, string nm, int s, logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rest();
    x = 10'd5;
    y = 10'd100;
  endtask

  task automatic vbl();
    x = 10'd0;
    y = 10'd480;
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    rest();
    tick();
    tick();
    tick();
    n = cyc;
    ex(n, "rst_start", SIG_START, 0);
    ex(n, "rst_tick", SIG_TICK, 0);
    ex(n, "rst_busy", SIG_BUSY, 0);
    ex(n, "rst_ovr", SIG_OVR, 0);
    ex(n, "rst_ostg", SIG_OSTG, 0);
    ex(n, "rst_cnt", SIG_CNT, 0);
    reset  = 1'b0;
    inv_on = 1;
    repeat (3) tick();

    // Normal frame, 3-cycle requesters
    enable = 1'b1;
    n = cyc;
    vbl();
    ex(n + 1, "nrm_tick", SIG_TICK, 1);
    ex(n + 1, "nrm_st0", SIG_START, 4'b0001);
    ex(n + 1, "nrm_busy", SIG_BUSY, 1);
    ex(n + 2, "nrm_tick_off", SIG_TICK, 0);
    ex(n + 2, "nrm_st_gap", SIG_START, 0);
    ex(n + 5, "nrm_st1", SIG_START, 4'b0010);
    ex(n + 9, "nrm_st2", SIG_START, 4'b0100);
    ex(n + 13, "nrm_st3", SIG_START, 4'b1000);
    ex(n + 16, "nrm_busy_hi", SIG_BUSY, 1);
    ex(n + 16, "nrm_cnt_pre", SIG_CNT, cnt(0));
    ex(n + 17, "nrm_busy_lo", SIG_BUSY, 0);
    ex(n + 17, "nrm_cnt", SIG_CNT, cnt(1));
    ex(n + 18, "nrm_st_idle", SIG_START, 0);
    tick();
    rest();
    repeat (20) tick();

    // Zero-wait requesters
    mode = M_ZERO;
    n = cyc;
    vbl();
    ex(n + 1, "zw_st0", SIG_START, 4'b0001);
    ex(n + 2, "zw_st1", SIG_START, 4'b0010);
    ex(n + 3, "zw_st2", SIG_START, 4'b0100);
    ex(n + 4, "zw_st3", SIG_START, 4'b1000);
    ex(n + 4, "zw_busy_hi", SIG_BUSY, 1);
    ex(n + 5, "zw_busy_lo", SIG_BUSY, 0);
    ex(n + 5, "zw_cnt", SIG_CNT, cnt(2));
    ex(n + 6, "zw_st_idle", SIG_START, 0);
    tick();
    rest();
    repeat (8) tick();
    mode = M_RESP;
    repeat (3) tick();

    // Enable gating
    enable = 1'b0;
    n = cyc;
    vbl();
    ex(n + 1, "gate_tick", SIG_TICK, 0);
    ex(n + 1, "gate_st", SIG_START, 0);
    ex(n + 1, "gate_busy", SIG_BUSY, 0);
    ex(n + 2, "gate_busy2", SIG_BUSY, 0);
    tick();
    rest();
    repeat (5) tick();
    enable = 1'b1;
    n = cyc;
    vbl();
    ex(n + 1, "drop_tick", SIG_TICK, 1);
    ex(n + 5, "drop_st1", SIG_START, 4'b0010);
    ex(n + 13, "drop_st3", SIG_START, 4'b1000);
    ex(n + 17, "drop_busy_lo", SIG_BUSY, 0);
    ex(n + 17, "drop_cnt", SIG_CNT, cnt(3));
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) rest();
      if (k == 6) enable = 1'b0;
    end
    enable = 1'b1;
    repeat (3) tick();

    // Reset in RUN(2)
    n = cyc;
    vbl();
    ex(n + 1, "rmid_st0", SIG_START, 4'b0001);
    ex(n + 9, "rmid_st2", SIG_START, 4'b0100);
    ex(n + 11, "rmid_start", SIG_START, 0);
    ex(n + 11, "rmid_tick", SIG_TICK, 0);
    ex(n + 11, "rmid_busy", SIG_BUSY, 0);
    ex(n + 11, "rmid_ovr", SIG_OVR, 0);
    ex(n + 11, "rmid_ostg", SIG_OSTG, 0);
    ex(n + 11, "rmid_cnt", SIG_CNT, 0);
    ex(n + 13, "rmid_no_st3", SIG_START, 0);
    ex(n + 13, "rmid_idle", SIG_BUSY, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) rest();
      if (k == 10) reset = 1'b1;
      if (k == 11) reset = 1'b0;
    end
    n = cyc;
    vbl();
    ex(n + 1, "rst2_st0", SIG_START, 4'b0001);
    ex(n + 1, "rst2_tick", SIG_TICK, 1);
    ex(n + 17, "rst2_busy_lo", SIG_BUSY, 0);
    ex(n + 17, "rst2_cnt", SIG_CNT, cnt(1));
    tick();
    rest();
    repeat (20) tick();

    // Overrun with stage 2 stuck
    block_mask = 4'b0100;
    n = cyc;
    vbl();
    ex(n + 9, "ovr_st2", SIG_START, 4'b0100);
    ex(n + 15, "ovr_busy_pre", SIG_BUSY, 1);
    ex(n + 15, "ovr_flag_pre", SIG_OVR, 0);
    ex(n + 16, "ovr_busy", SIG_BUSY, 0);
    ex(n + 16, "ovr_flag", SIG_OVR, 1);
    ex(n + 16, "ovr_stage", SIG_OSTG, 2);
    ex(n + 16, "ovr_no_st", SIG_START, 0);
    ex(n + 16, "ovr_cnt", SIG_CNT, cnt(1));
    ex(n + 17, "ovr_no_st2", SIG_START, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) rest();
      if (k == 15) begin
        x = 10'd0;
        y = 10'd0;
      end
      if (k == 16) rest();
    end
    block_mask = 4'h0;
    n = cyc;
    vbl();
    ex(n + 1, "ovr2_st0", SIG_START, 4'b0001);
    ex(n + 1, "ovr2_sticky", SIG_OVR, 1);
    ex(n + 17, "ovr2_busy_lo", SIG_BUSY, 0);
    ex(n + 17, "ovr2_cnt", SIG_CNT, cnt(2));
    ex(n + 17, "ovr2_sticky2", SIG_OVR, 1);
    ex(n + 17, "ovr2_stage", SIG_OSTG, 2);
    tick();
    rest();
    repeat (20) tick();

    // Deadline coincident with stage_done[3]
    mode = M_MAN;
    man_done = 4'b0111;
    n = cyc;
    vbl();
    ex(n + 1, "sim_st0", SIG_START, 4'b0001);
    ex(n + 2, "sim_st1", SIG_START, 4'b0010);
    ex(n + 3, "sim_st2", SIG_START, 4'b0100);
    ex(n + 4, "sim_st3", SIG_START, 4'b1000);
    ex(n + 6, "sim_busy_pre", SIG_BUSY, 1);
    ex(n + 7, "sim_busy", SIG_BUSY, 0);
    ex(n + 7, "sim_ovr", SIG_OVR, 1);
    ex(n + 7, "sim_stage", SIG_OSTG, 3);
    ex(n + 7, "sim_no_st", SIG_START, 0);
    ex(n + 7, "sim_cnt", SIG_CNT, cnt(2));
    ex(n + 8, "sim_cnt2", SIG_CNT, cnt(2));
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) rest();
      if (k == 6) begin
        x = 10'd0;
        y = 10'd0;
        man_done = 4'b1111;
      end
      if (k == 7) begin
        rest();
        man_done = 4'b0000;
      end
    end
    mode = M_RESP;
    repeat (5) tick();

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      nvec++;
      nbad++;
      $display("FAIL %s never checked got=none want=%0h", e.nm, e.val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
